// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache stage.
package dcache_pkg;

  localparam int BYTE_W = 8;

  // ldSt_enable bit positions; both bits set is treated as a load.
  localparam int LD_BIT = 1;
  localparam int ST_BIT = 0;

  // Default geometry and the address split derived from it.
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_WORD_WIDTH = 16;
  localparam int DEF_LINE_BYTES = 32;
  localparam int DEF_NUM_LINES  = 4;
  localparam int DEF_OFF        = $clog2(DEF_LINE_BYTES);
  localparam int DEF_IDX        = $clog2(DEF_NUM_LINES);
  localparam int DEF_TAG        = DEF_ADDR_WIDTH - DEF_OFF - DEF_IDX;

  typedef enum logic [1:0] {IDLE, WB, FILL} dc_state_e;

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one byte-enabled
// word write port (store hits) and one full-line fill port (refills).
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int TAG_W      = DEF_TAG,
  parameter int IDX_W      = $clog2(NUM_LINES),
  parameter int OFF_W      = $clog2(LINE_BYTES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IDX_W-1:0]             rd_idx,
  output logic                         rd_valid,
  output logic                         rd_dirty,
  output logic [TAG_W-1:0]             rd_tag,
  output logic [LINE_BYTES*BYTE_W-1:0] rd_line,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [OFF_W-1:0]             wr_off,
  input  logic [1:0]                   wr_be,
  input  logic [2*BYTE_W-1:0]          wr_data,
  input  logic                         fill_en,
  input  logic [IDX_W-1:0]             fill_idx,
  input  logic [TAG_W-1:0]             fill_tag,
  input  logic [LINE_BYTES*BYTE_W-1:0] fill_line
);

  logic [NUM_LINES-1:0]          valid;
  logic [NUM_LINES-1:0]          dirty;
  logic [TAG_W-1:0]              tag_mem  [NUM_LINES];
  logic [LINE_BYTES*BYTE_W-1:0]  data_mem [NUM_LINES];

  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];

  // Line state: a fill makes the line valid and clean, a store dirties it.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (fill_en) begin
        valid[fill_idx] <= 1'b1;
        dirty[fill_idx] <= 1'b0;
      end
      if (wr_en) dirty[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage are left unreset; valid gates every use of them.
  // wr_off is word-aligned when both byte enables are set, so off|1 is the high byte.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_line;
    end
    if (wr_en && wr_be[0])
      data_mem[wr_idx][{wr_off, 3'b000} +: BYTE_W] <= wr_data[BYTE_W-1:0];
    if (wr_en && wr_be[1])
      data_mem[wr_idx][{wr_off[OFF_W-1:1], 1'b1, 3'b000} +: BYTE_W] <= wr_data[2*BYTE_W-1:BYTE_W];
  end

endmodule

// File: rtl/dcache_stage_wb.sv
// CACHE pipeline stage: latches the TLB-stage outputs, looks them up in a
// direct-mapped write-back cache and runs the evict/refill FSM on a miss.
module dcache_stage_wb
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int NUM_LINES  = DEF_NUM_LINES
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     enable_cache,
  input  logic [ADDR_WIDTH-1:0]                    tlb_result,
  input  logic [WORD_WIDTH-1:0]                    dataReg,
  input  logic [1:0]                               ldSt_enable,
  input  logic                                     word_access_from_tlb,
  input  logic [2:0]                               destReg_addr_input,
  input  logic                                     we_input,
  input  logic [1:0]                               bp_input,
  output logic [WORD_WIDTH-1:0]                    cache_result,
  output logic [2:0]                               destReg_addr_output,
  output logic                                     we_output,
  output logic [1:0]                               bp_output,
  output logic                                     word_access,
  output logic                                     stall,
  output logic                                     mem_req,
  output logic                                     mem_we,
  output logic [ADDR_WIDTH-$clog2(LINE_BYTES)-1:0] mem_addr,
  output logic [LINE_BYTES*8-1:0]                  mem_wdata,
  input  logic [LINE_BYTES*8-1:0]                  mem_rdata,
  input  logic                                     mem_ack
);

  localparam int OFF    = $clog2(LINE_BYTES);
  localparam int IDX    = $clog2(NUM_LINES);
  localparam int TAG    = ADDR_WIDTH - OFF - IDX;
  localparam int LINE_W = LINE_BYTES * BYTE_W;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WORD_WIDTH-1:0] data_q;
  logic [1:0]            ldst_q;
  logic                  word_q, we_q;
  logic [2:0]            dst_q;
  logic [1:0]            bp_q;
  dc_state_e             state;

  // Stage register; frozen while a miss is being serviced.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0; data_q <= '0; ldst_q <= '0; word_q <= 1'b0;
      we_q   <= 1'b0; dst_q <= '0; bp_q  <= '0;
    end else if (enable_cache && !stall) begin
      addr_q <= tlb_result;        data_q <= dataReg;   ldst_q <= ldSt_enable;
      word_q <= word_access_from_tlb; we_q <= we_input; dst_q <= destReg_addr_input;
      bp_q   <= bp_input;
    end
  end

  logic            is_load, is_store, is_mem;
  logic [OFF-1:0]  off, off_lo;
  logic [IDX-1:0]  idx;
  logic [TAG-1:0]  tag;

  assign is_load  = ldst_q[LD_BIT];
  assign is_store = ldst_q[ST_BIT] && !ldst_q[LD_BIT];
  assign is_mem   = is_load || is_store;
  assign off      = addr_q[OFF-1:0];
  assign idx      = addr_q[OFF+IDX-1:OFF];
  assign tag      = addr_q[ADDR_WIDTH-1:OFF+IDX];
  // Word accesses ignore address bit 0.
  assign off_lo   = word_q ? {off[OFF-1:1], 1'b0} : off;

  logic              rd_valid, rd_dirty, hit;
  logic [TAG-1:0]    rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic [BYTE_W-1:0] b_lo, b_hi;

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_BYTES(LINE_BYTES),
    .TAG_W     (TAG),
    .IDX_W     (IDX),
    .OFF_W     (OFF)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (is_store && hit),
    .wr_idx   (idx),
    .wr_off   (off_lo),
    .wr_be    (word_q ? 2'b11 : 2'b01),
    .wr_data  (data_q[2*BYTE_W-1:0]),
    .fill_en  (state == FILL && mem_ack),
    .fill_idx (idx),
    .fill_tag (tag),
    .fill_line(mem_rdata)
  );

  assign hit   = rd_valid && (rd_tag == tag);
  // Miss is visible in the same cycle; it clears the cycle after the refill lands.
  assign stall = is_mem && !hit;

  // Little-endian word: low byte at off_lo, high byte at off_lo+1.
  assign b_lo = rd_line[{off_lo, 3'b000} +: BYTE_W];
  assign b_hi = rd_line[{off[OFF-1:1], 1'b1, 3'b000} +: BYTE_W];

  assign cache_result        = !is_load ? WORD_WIDTH'(addr_q) :
                               word_q   ? WORD_WIDTH'({b_hi, b_lo}) : WORD_WIDTH'(b_lo);
  assign destReg_addr_output = dst_q;
  assign we_output           = we_q && !stall;
  assign bp_output           = bp_q;
  assign word_access         = word_q;

  // Miss FSM: optional dirty-victim writeback, then line refill. Request
  // outputs are registered so they hold steady until mem_ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (stall) begin
          mem_req <= 1'b1;
          if (rd_valid && rd_dirty) begin
            state     <= WB;
            mem_we    <= 1'b1;
            mem_addr  <= {rd_tag, idx};
            mem_wdata <= rd_line;
          end else begin
            state    <= FILL;
            mem_we   <= 1'b0;
            mem_addr <= {tag, idx};
          end
        end
        WB: if (mem_ack) begin
          state    <= FILL;
          mem_we   <= 1'b0;
          mem_addr <= {tag, idx};
        end
        FILL: if (mem_ack) begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
